// File: rtl/piso_8_bit.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Streams each accepted word one bit per clock, with frame-valid and last-bit markers.
module piso_8_bit #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg, sreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] sreg_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
        end
    end

    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // Outputs depend only on registered state, never on load or d_in.
    assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign ready   = (state == IDLE) || last;
    assign d_valid = (state == SHIFT);
    assign d_out   = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;

    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    sreg_next  = d_in;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // Final bit: either chain straight into the next word or drop back to idle.
                    if (load) begin
                        sreg_next = d_in;
                        cnt_next  = '0;
                    end else begin
                        sreg_next  = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    sreg_next = sreg_shifted;
                    cnt_next  = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                sreg_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_8_bit.sv
// Bench for piso_8_bit: MSB-first and LSB-first instances share one stimulus stream,
// each checked every cycle against a bit-queue model plus hand-computed stream literals.
module tb_piso_8_bit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic             ready_m, d_out_m, d_valid_m, last_m;
    logic             ready_l, d_out_l, d_valid_l, last_l;

    int n_checks;
    int n_fails;

    bit q_msb[$];
    bit q_lsb[$];

    piso_8_bit #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in),
        .ready(ready_m), .d_out(d_out_m), .d_valid(d_valid_m), .last(last_m)
    );

    piso_8_bit #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in),
        .ready(ready_l), .d_out(d_out_l), .d_valid(d_valid_l), .last(last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model: each queue holds the bits still to be shown, in transmit order; a word
    // is accepted when at most its final bit remains, so the queue never mixes words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_msb.delete();
            q_lsb.delete();
        end else begin
            int pre_m;
            int pre_l;
            pre_m = q_msb.size();
            pre_l = q_lsb.size();
            if (pre_m > 0) void'(q_msb.pop_front());
            if (pre_l > 0) void'(q_lsb.pop_front());
            if (load && pre_m <= 1)
                for (int i = 0; i < WIDTH; i++) q_msb.push_back(d_in[WIDTH-1-i]);
            if (load && pre_l <= 1)
                for (int i = 0; i < WIDTH; i++) q_lsb.push_back(d_in[i]);
        end
    end

    always @(negedge clk) begin
        checkOutput("msb.d_valid", 16'(d_valid_m), 16'(q_msb.size() > 0));
        checkOutput("msb.d_out",   16'(d_out_m),   16'((q_msb.size() > 0) ? q_msb[0] : 1'b0));
        checkOutput("msb.last",    16'(last_m),    16'(q_msb.size() == 1));
        checkOutput("msb.ready",   16'(ready_m),   16'(q_msb.size() <= 1));
        checkOutput("lsb.d_valid", 16'(d_valid_l), 16'(q_lsb.size() > 0));
        checkOutput("lsb.d_out",   16'(d_out_l),   16'((q_lsb.size() > 0) ? q_lsb[0] : 1'b0));
        checkOutput("lsb.last",    16'(last_l),    16'(q_lsb.size() == 1));
        checkOutput("lsb.ready",   16'(ready_l),   16'(q_lsb.size() <= 1));
    end

    // Present a word for exactly one accepting edge; returns at the negedge of bit 0.
    task automatic applyStimulus(input logic [WIDTH-1:0] word);
        @(negedge clk);
        load = 1'b1;
        d_in = word;
        @(negedge clk);
        load = 1'b0;
        d_in = WIDTH'($urandom);
    endtask

    // Sample n cycles (first sample goes to the top bit); optionally pulse load at cycle pulse_at.
    task automatic collect(input int n, input int pulse_at, input logic [WIDTH-1:0] pulse_word,
                           output logic [15:0] bits_m, output logic [15:0] bits_l,
                           output logic [15:0] lasts_m, output logic [15:0] valids_m,
                           output logic [15:0] readys_m);
        bits_m = '0; bits_l = '0; lasts_m = '0; valids_m = '0; readys_m = '0;
        for (int i = 0; i < n; i++) begin
            bits_m   = {bits_m[14:0], d_out_m};
            bits_l   = {bits_l[14:0], d_out_l};
            lasts_m  = {lasts_m[14:0], last_m};
            valids_m = {valids_m[14:0], d_valid_m};
            readys_m = {readys_m[14:0], ready_m};
            if (i == pulse_at) begin
                load = 1'b1;
                d_in = pulse_word;
            end else if (i == pulse_at + 1) begin
                load = 1'b0;
                d_in = WIDTH'($urandom);
            end
            @(negedge clk);
        end
    endtask

    logic [15:0] bm, bl, lm, vm, rm;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        d_in     = '0;

        // Reset, then idle with load low.
        repeat (3) @(negedge clk);
        checkOutput("reset.ready", 16'({ready_m, ready_l}), 16'h3);
        checkOutput("reset.d_valid", 16'({d_valid_m, d_valid_l}), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_in = WIDTH'($urandom);
            checkOutput("idle.outs", 16'({d_valid_m, d_out_m, last_m, ready_m}), 16'h1);
        end
        d_in = '0;

        // Single word A5.
        applyStimulus(8'hA5);
        collect(8, -1, '0, bm, bl, lm, vm, rm);
        checkOutput("a5.msb_stream", bm, 16'h00A5);
        checkOutput("a5.lsb_stream", bl, 16'h00A5);
        checkOutput("a5.last", lm, 16'h0001);
        checkOutput("a5.valid", vm, 16'h00FF);
        checkOutput("a5.after", 16'({d_valid_m, ready_m}), 16'h1);

        // LSB-first 0F.
        applyStimulus(8'h0F);
        collect(8, -1, '0, bm, bl, lm, vm, rm);
        checkOutput("0f.lsb_stream", bl, 16'h00F0);
        checkOutput("0f.msb_stream", bm, 16'h000F);

        // Back-to-back C3 then 3C, chained during the last-bit cycle.
        applyStimulus(8'hC3);
        collect(16, 7, 8'h3C, bm, bl, lm, vm, rm);
        checkOutput("b2b.msb_stream", bm, 16'hC33C);
        checkOutput("b2b.last", lm, 16'h0101);
        checkOutput("b2b.valid", vm, 16'hFFFF);
        checkOutput("b2b.after", 16'(d_valid_m), 16'h0);

        // Load while busy is ignored.
        applyStimulus(8'hFF);
        collect(8, 2, 8'h00, bm, bl, lm, vm, rm);
        checkOutput("busy.msb_stream", bm, 16'h00FF);
        checkOutput("busy.lsb_stream", bl, 16'h00FF);
        checkOutput("busy.ready", rm, 16'h0001);
        checkOutput("busy.after", 16'({d_valid_m, d_valid_l}), 16'h0);

        // Asynchronous reset during the 4th bit of AA.
        applyStimulus(8'hAA);
        collect(3, -1, '0, bm, bl, lm, vm, rm);
        checkOutput("rst.pre_lsb", 16'({d_valid_l, d_out_l}), 16'h3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async_msb", 16'({d_valid_m, d_out_m, last_m, ready_m}), 16'h1);
        checkOutput("rst.async_lsb", 16'({d_valid_l, d_out_l, last_l, ready_l}), 16'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst.idle", 16'({d_valid_m, d_valid_l, ready_m, ready_l}), 16'h3);
        end
        applyStimulus(8'h81);
        collect(8, -1, '0, bm, bl, lm, vm, rm);
        checkOutput("rst.81_msb", bm, 16'h0081);
        checkOutput("rst.81_lsb", bl, 16'h0081);
        checkOutput("rst.81_last", lm, 16'h0001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
